plru_victim_alloc: RTL and testbench

Victim-way allocator for set/fully-associative structures (TLB, small caches, fill buffers). Sits in front of the PLRU replacement tree and owns it: it turns lookup hits and completed fills into access masks for the tree, and turns its least-used mask plus entry valid/lock state into a one-hot victim handed to the refill engine through a valid/ready handshake. Refill controllers instantiate this block instead of wiring the replacement tree directly.

---
 rtl/plru_alloc_pkg.sv | 29 ++
 rtl/plru_victim_alloc_tree.sv | 94 +++++++++
 rtl/plru_victim_alloc.sv | 171 +++++++++++++++++
 tb/tb_plru_victim_alloc.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_alloc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plru_alloc_pkg
//  Description : Shared definitions for the PLRU victim allocator: the
//                allocator FSM state type and the lowest-set-bit helper used
//                by the victim fallback paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package plru_alloc_pkg;

    // Widest mask the helper handles; ENTRY_COUNT must not exceed this.
    localparam int c_MAX_ENTRIES = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SELECT    = 2'd1,
        RESP      = 2'd2,
        FILL_WAIT = 2'd3
    } alloc_state_e;

    // Isolate the lowest set bit: x & -x. Zero in gives zero out.
    function automatic logic [c_MAX_ENTRIES-1:0] onehot_lowest(
        input logic [c_MAX_ENTRIES-1:0] mask
    );
        return mask & (~mask + c_MAX_ENTRIES'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/plru_victim_alloc_tree.sv
`default_nettype none
// ============================================================================
//  Module      : plru_victim_alloc_tree
//  Description : Binary-tree pseudo-LRU state. Each internal node points at
//                the less recently used half of its subtree (0 = lower half,
//                1 = upper half). An access flips every node on its path to
//                point away from the accessed leaf; the least-used leaf is
//                found by walking the node pointers from the root.
//  Ports       : clk, rstn        clock, async active-low reset (nodes -> 0)
//                access_mask      one-hot access this cycle (zero = none)
//                lru_mask         one-hot least-recently-used leaf
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_victim_alloc_tree #(
    parameter int ENTRY_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [ENTRY_COUNT-1:0] access_mask,
    output logic [ENTRY_COUNT-1:0] lru_mask
);

    localparam int c_LEVELS = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam int c_NODES  = (ENTRY_COUNT > 1) ? ENTRY_COUNT - 1 : 1;

    if (ENTRY_COUNT > 1) begin : g_tree
        // Heap layout: node at level l, position p lives at (2^l - 1) + p.
        logic [c_NODES-1:0]  r_nodes;
        logic [c_NODES-1:0]  w_nodes_next;
        logic [c_LEVELS-1:0] w_acc_idx;
        logic [c_LEVELS-1:0] w_lru_idx;
        logic                w_acc_any;

        always_comb begin
            w_acc_idx = '0;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                if (access_mask[i]) begin
                    w_acc_idx = c_LEVELS'(i);
                end
            end
        end

        assign w_acc_any = |access_mask;

        // The node on the access path at level l is selected by the top l
        // bits of the leaf index; it is set to point at the other half.
        always_comb begin
            w_nodes_next = r_nodes;
            for (int l = 0; l < c_LEVELS; l++) begin
                for (int n = 0; n < c_NODES; n++) begin
                    if (n == (1 << l) - 1 + int'(w_acc_idx >> (c_LEVELS - l))) begin
                        w_nodes_next[n] = ~w_acc_idx[c_LEVELS-1-l];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_nodes <= '0;
            end else if (w_acc_any) begin
                r_nodes <= w_nodes_next;
            end
        end

        // Walk from the root; each visited node contributes one index bit.
        always_comb begin
            w_lru_idx = '0;
            for (int l = 0; l < c_LEVELS; l++) begin
                for (int n = 0; n < c_NODES; n++) begin
                    if (n == (1 << l) - 1 + int'(w_lru_idx >> (c_LEVELS - l))) begin
                        w_lru_idx[c_LEVELS-1-l] = r_nodes[n];
                    end
                end
            end
        end

        always_comb begin
            lru_mask = '0;
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                if (w_lru_idx == c_LEVELS'(i)) begin
                    lru_mask[i] = 1'b1;
                end
            end
        end
    end else begin : g_single
        // A single way is always the least used; there is no state.
        logic w_unused_single;
        assign w_unused_single = ^{access_mask, clk, rstn};
        assign lru_mask        = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/plru_victim_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : plru_victim_alloc
//  Description : Victim-way allocator that owns a PLRU tree. Lookup hits and
//                completed fills become tree accesses; a victim request is
//                answered with a one-hot way chosen from entry valid/lock
//                state and the tree's least-used way.
//  Ports       : clk, rstn                         clock, async active-low reset
//                entry_valid_i                     per-entry valid bits
//                lock_mask_i                       entries excluded from choice
//                hit_valid_i / hit_mask_i          lookup hit (one-hot)
//                alloc_req_valid_i / _ready_o      victim request handshake
//                alloc_resp_valid_o / _ready_i     victim response handshake
//                alloc_way_mask_o                  one-hot victim (RESP only)
//                fill_done_i / fill_abort_i        refill outcome
//                hit_dropped_o                     hit lost to a fill commit
//  Options     : PLRU_ALLOC_LOCK_EN - honour lock_mask_i; otherwise every
//                entry is a candidate and lock_mask_i is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_victim_alloc
    import plru_alloc_pkg::*;
#(
    parameter int ENTRY_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [ENTRY_COUNT-1:0] entry_valid_i,
    input  logic [ENTRY_COUNT-1:0] lock_mask_i,
    input  logic                   hit_valid_i,
    input  logic [ENTRY_COUNT-1:0] hit_mask_i,
    input  logic                   alloc_req_valid_i,
    output logic                   alloc_req_ready_o,
    output logic                   alloc_resp_valid_o,
    input  logic                   alloc_resp_ready_i,
    output logic [ENTRY_COUNT-1:0] alloc_way_mask_o,
    input  logic                   fill_done_i,
    input  logic                   fill_abort_i,
    output logic                   hit_dropped_o
);

    alloc_state_e           r_state;
    alloc_state_e           w_state_next;
    logic [ENTRY_COUNT-1:0] r_victim_q;
    logic [ENTRY_COUNT-1:0] w_victim_next;
    logic                   r_hit_dropped;

    logic [ENTRY_COUNT-1:0] w_cand;
    logic [ENTRY_COUNT-1:0] w_inval;
    logic [ENTRY_COUNT-1:0] w_lru_mask;
    logic [ENTRY_COUNT-1:0] w_lru_cand;
    logic [ENTRY_COUNT-1:0] w_low_inval;
    logic [ENTRY_COUNT-1:0] w_low_cand;
    logic [ENTRY_COUNT-1:0] w_pick;
    logic [ENTRY_COUNT-1:0] w_access_mask;
    logic                   w_have_cand;
    logic                   w_commit;

    // ------------------------------------------------------------------
    // Candidate set
    // ------------------------------------------------------------------
`ifdef PLRU_ALLOC_LOCK_EN
    assign w_cand = ~lock_mask_i;
`else
    logic w_unused_lock;
    assign w_cand        = '1;
    assign w_unused_lock = ^lock_mask_i;
`endif

    assign w_have_cand = |w_cand;
    assign w_inval     = w_cand & ~entry_valid_i;
    assign w_lru_cand  = w_lru_mask & w_cand;
    assign w_low_inval = ENTRY_COUNT'(onehot_lowest(c_MAX_ENTRIES'(w_inval)));
    assign w_low_cand  = ENTRY_COUNT'(onehot_lowest(c_MAX_ENTRIES'(w_cand)));

    // Empty slots first, then the PLRU choice, then any unlocked way.
    always_comb begin
        if (|w_inval) begin
            w_pick = w_low_inval;
        end else if (|w_lru_cand) begin
            w_pick = w_lru_mask;
        end else begin
            w_pick = w_low_cand;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_victim_next = r_victim_q;
        w_commit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (alloc_req_valid_i) begin
                    w_state_next = SELECT;
                end
            end
            SELECT: begin
                // Valid/lock are sampled only here; the victim is then frozen.
                if (w_have_cand) begin
                    w_victim_next = w_pick;
                    w_state_next  = RESP;
                end
            end
            RESP: begin
                if (alloc_resp_ready_i) begin
                    w_state_next = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (fill_done_i) begin
                    w_commit     = 1'b1;
                    w_state_next = IDLE;
                end else if (fill_abort_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A fill commit owns the tree port; a same-cycle hit is discarded.
    always_comb begin
        if (w_commit) begin
            w_access_mask = r_victim_q;
        end else if (hit_valid_i) begin
            w_access_mask = hit_mask_i;
        end else begin
            w_access_mask = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_victim_q    <= '0;
            r_hit_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_victim_q    <= w_victim_next;
            r_hit_dropped <= w_commit & hit_valid_i;
        end
    end

    plru_victim_alloc_tree #(
        .ENTRY_COUNT (ENTRY_COUNT)
    ) u_tree (
        .clk         (clk),
        .rstn        (rstn),
        .access_mask (w_access_mask),
        .lru_mask    (w_lru_mask)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gated by rstn so the request side reads not-ready while held in reset.
    assign alloc_req_ready_o  = (r_state == IDLE) & rstn;
    assign alloc_resp_valid_o = (r_state == RESP);
    assign alloc_way_mask_o   = (r_state == RESP) ? r_victim_q : '0;
    assign hit_dropped_o      = r_hit_dropped;

    a_hit_onehot : assert property (@(posedge clk) disable iff (!rstn)
        hit_valid_i |-> $onehot0(hit_mask_i));

endmodule
`default_nettype wire

// File: tb/tb_plru_victim_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plru_victim_alloc
//  Description : Self-checking bench for plru_victim_alloc (ENTRY_COUNT=4).
//                A reference model tracks, per way, the time of its last
//                access; the least-used way is found by halving the range,
//                stepping away from the half holding the most recent access.
//                Directed scenarios pin exact victims; a random phase is
//                checked against the model on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plru_victim_alloc;

    localparam int N = 4;
`ifdef PLRU_ALLOC_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_SEL  = 1;
    localparam int M_RESP = 2;
    localparam int M_FILL = 3;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] entry_valid_i;
    logic [N-1:0] lock_mask_i;
    logic         hit_valid_i;
    logic [N-1:0] hit_mask_i;
    logic         alloc_req_valid_i;
    logic         alloc_resp_ready_i;
    logic         fill_done_i;
    logic         fill_abort_i;
    wire          alloc_req_ready_o;
    wire          alloc_resp_valid_o;
    wire  [N-1:0] alloc_way_mask_o;
    wire          hit_dropped_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    plru_victim_alloc #(.ENTRY_COUNT(N)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .entry_valid_i      (entry_valid_i),
        .lock_mask_i        (lock_mask_i),
        .hit_valid_i        (hit_valid_i),
        .hit_mask_i         (hit_mask_i),
        .alloc_req_valid_i  (alloc_req_valid_i),
        .alloc_req_ready_o  (alloc_req_ready_o),
        .alloc_resp_valid_o (alloc_resp_valid_o),
        .alloc_resp_ready_i (alloc_resp_ready_i),
        .alloc_way_mask_o   (alloc_way_mask_o),
        .fill_done_i        (fill_done_i),
        .fill_abort_i       (fill_abort_i),
        .hit_dropped_o      (hit_dropped_o)
    );

    // ------------------------------------------------------------------
    // Checkers
    // ------------------------------------------------------------------
    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int           m_state;
    logic [N-1:0] m_victim;
    logic         m_drop;
    int           last_t [N];
    int           m_time;
    logic         m_commit;
    logic [N-1:0] m_pick;

    function automatic int lowest_idx(input logic [N-1:0] m);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) r = i;
        end
        return r;
    endfunction

    function automatic int model_lru(input int lt [N]);
        int lo, hi, mid, best_t, best_w;
        lo = 0;
        hi = N;
        while (hi - lo > 1) begin
            mid    = (lo + hi) / 2;
            best_t = 0;
            best_w = -1;
            for (int w = 0; w < N; w++) begin
                if (w >= lo && w < hi && lt[w] > best_t) begin
                    best_t = lt[w];
                    best_w = w;
                end
            end
            if (best_w < 0 || best_w >= mid) hi = mid;
            else                             lo = mid;
        end
        return lo;
    endfunction

    function automatic logic [N-1:0] model_pick(input logic [N-1:0] valid,
                                                input logic [N-1:0] lock,
                                                input int lt [N]);
        logic [N-1:0] cand;
        int           k;
        cand = LOCK_EN ? ~lock : {N{1'b1}};
        if (cand == '0) return '0;
        k = lowest_idx(cand & ~valid);
        if (k < 0) begin
            k = model_lru(lt);
            if (!cand[k]) k = lowest_idx(cand);
        end
        return N'(1) << k;
    endfunction

    always_comb begin
        m_commit = (m_state == M_FILL) && fill_done_i;
        m_pick   = model_pick(entry_valid_i, lock_mask_i, last_t);
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state  <= M_IDLE;
            m_victim <= '0;
            m_drop   <= 1'b0;
            m_time   <= 1;
            for (int w = 0; w < N; w++) last_t[w] <= 0;
        end else begin
            m_drop <= m_commit && hit_valid_i;
            if (m_commit) begin
                last_t[lowest_idx(m_victim)] <= m_time;
                m_time <= m_time + 1;
            end else if (hit_valid_i && hit_mask_i != '0) begin
                last_t[lowest_idx(hit_mask_i)] <= m_time;
                m_time <= m_time + 1;
            end
            case (m_state)
                M_IDLE: if (alloc_req_valid_i) m_state <= M_SEL;
                M_SEL:  if (m_pick != '0) begin
                            m_victim <= m_pick;
                            m_state  <= M_RESP;
                        end
                M_RESP: if (alloc_resp_ready_i) m_state <= M_FILL;
                default: if (fill_done_i || fill_abort_i) m_state <= M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check_bit("req_ready", alloc_req_ready_o, (m_state == M_IDLE) && rstn);
        check_bit("resp_valid", alloc_resp_valid_o, m_state == M_RESP);
        check_vec("way_mask", alloc_way_mask_o, (m_state == M_RESP) ? m_victim : '0);
        check_bit("hit_dropped", hit_dropped_o, m_drop);
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int k;
        k = 0;
        while (!alloc_req_ready_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_bit("wait_idle_ready", alloc_req_ready_o, 1'b1);
    endtask

    // Request accepted at the next edge; SELECT one cycle, then RESP.
    task automatic do_request(input logic [N-1:0] exp, input string nm);
        wait_idle();
        alloc_req_valid_i = 1'b1;
        @(negedge clk);
        alloc_req_valid_i = 1'b0;
        check_bit({nm, "_select_no_resp"}, alloc_resp_valid_o, 1'b0);
        @(negedge clk);
        check_bit({nm, "_resp_valid"}, alloc_resp_valid_o, 1'b1);
        check_vec(nm, alloc_way_mask_o, exp);
    endtask

    task automatic end_fill(input logic done, input logic abort, input logic with_hit);
        alloc_resp_ready_i = 1'b1;
        @(negedge clk);
        alloc_resp_ready_i = 1'b0;
        fill_done_i        = done;
        fill_abort_i       = abort;
        hit_valid_i        = with_hit;
        hit_mask_i         = 4'b0010;
        @(negedge clk);
        fill_done_i  = 1'b0;
        fill_abort_i = 1'b0;
        hit_valid_i  = 1'b0;
    endtask

    task automatic hit(input int w);
        hit_valid_i = 1'b1;
        hit_mask_i  = N'(1) << w;
        @(negedge clk);
        hit_valid_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        rstn               = 1'b0;
        entry_valid_i      = '0;
        lock_mask_i        = '0;
        hit_valid_i        = 1'b0;
        hit_mask_i         = '0;
        alloc_req_valid_i  = 1'b0;
        alloc_resp_ready_i = 1'b0;
        fill_done_i        = 1'b0;
        fill_abort_i       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_bit("rst_req_ready", alloc_req_ready_o, 1'b0);
        check_bit("rst_resp_valid", alloc_resp_valid_o, 1'b0);
        check_vec("rst_way_mask", alloc_way_mask_o, 4'b0000);
        check_bit("rst_hit_dropped", hit_dropped_o, 1'b0);
        #2 rstn = 1'b1;
        @(negedge clk);
        check_bit("post_rst_ready", alloc_req_ready_o, 1'b1);

        // Empty structure: lowest invalid way, held while not consumed
        entry_valid_i = 4'b0000;
        do_request(4'b0001, "empty_victim");
        repeat (5) begin
            @(negedge clk);
            check_bit("hold_resp_valid", alloc_resp_valid_o, 1'b1);
            check_vec("hold_way_mask", alloc_way_mask_o, 4'b0001);
        end
        end_fill(1'b0, 1'b1, 1'b0);

        // All valid, hits 0..3 -> way 0; after filling 0 -> way 2
        entry_valid_i = 4'b1111;
        hit(0); hit(1); hit(2); hit(3);
        do_request(4'b0001, "plru_after_hits");
        end_fill(1'b1, 1'b0, 1'b0);
        do_request(4'b0100, "plru_after_fill");
        end_fill(1'b0, 1'b1, 1'b0);

        // Invalid entry beats the PLRU choice
        hit(0); hit(1); hit(2); hit(3);
        entry_valid_i = 4'b1011;
        do_request(4'b0100, "invalid_first");
        end_fill(1'b0, 1'b1, 1'b0);

        // Fill commit collides with a hit on way 1
        entry_valid_i = 4'b1111;
        hit(2); hit(3); hit(0); hit(1);
        do_request(4'b0100, "pre_collision");
        end_fill(1'b1, 1'b0, 1'b1);
        check_bit("drop_pulse", hit_dropped_o, 1'b1);
        @(negedge clk);
        check_bit("drop_clear", hit_dropped_o, 1'b0);
        do_request(4'b0001, "victim_only_commit");
        end_fill(1'b0, 1'b1, 1'b0);
        do_request(4'b0001, "abort_no_update");
        end_fill(1'b0, 1'b1, 1'b0);

        // Reset while a response is pending
        hit(0);
        do_request(4'b1000, "pre_reset");
        #2 rstn = 1'b0;
        #1;
        check_bit("async_resp_drop", alloc_resp_valid_o, 1'b0);
        check_vec("async_mask_drop", alloc_way_mask_o, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        do_request(4'b0001, "post_reset_victim");
        end_fill(1'b0, 1'b1, 1'b0);

`ifdef PLRU_ALLOC_LOCK_EN
        // PLRU points at way 0 but it is locked
        lock_mask_i = 4'b0011;
        do_request(4'b0100, "lock_skip_plru");
        end_fill(1'b0, 1'b1, 1'b0);
        // Everything locked: SELECT stalls until a way is released
        lock_mask_i = 4'b1111;
        wait_idle();
        alloc_req_valid_i = 1'b1;
        @(negedge clk);
        alloc_req_valid_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_bit("lock_stall", alloc_resp_valid_o, 1'b0);
        end
        lock_mask_i = 4'b0111;
        @(negedge clk);
        check_bit("lock_release_valid", alloc_resp_valid_o, 1'b1);
        check_vec("lock_release_mask", alloc_way_mask_o, 4'b1000);
        end_fill(1'b0, 1'b1, 1'b0);
        lock_mask_i = 4'b0000;
`endif

        // Random phase, checked against the model every cycle
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            entry_valid_i      = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
            lock_mask_i        = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b0000;
            hit_valid_i        = ($urandom_range(0, 2) == 0);
            hit_mask_i         = N'(1) << $urandom_range(0, N - 1);
            alloc_req_valid_i  = ($urandom_range(0, 1) == 0);
            alloc_resp_ready_i = ($urandom_range(0, 2) != 0);
            fill_done_i        = ($urandom_range(0, 3) == 0);
            fill_abort_i       = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rstn = 1'b0;
                @(negedge clk);
                #2 rstn = 1'b1;
            end
        end

        hit_valid_i        = 1'b0;
        alloc_req_valid_i  = 1'b0;
        alloc_resp_ready_i = 1'b0;
        fill_done_i        = 1'b0;
        fill_abort_i       = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
